// File: rtl/unpool_pkg.sv
// ============================================================================
// Module      : unpool_pkg
// Description : Shared types and constants for the 2x2 unpool stage.
//               Optional feature macro: MAX_UNPOOL_EN (max-unpool mode).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package unpool_pkg;

    typedef enum logic [0:0] {
        S_TOP = 1'b0,
        S_BOT = 1'b1
    } state_t;

    // Position inside a 2x2 block, encoded {bottom_row, right_col}
    localparam logic [1:0] POS_TL = 2'd0;
    localparam logic [1:0] POS_TR = 2'd1;
    localparam logic [1:0] POS_BL = 2'd2;
    localparam logic [1:0] POS_BR = 2'd3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/unpool_row_buf.sv
// ============================================================================
// Module      : unpool_row_buf
// Description : One-row register buffer; written on the top row of each
//               block and replayed on the bottom row.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unpool_row_buf
    import unpool_pkg::*;
#(
    parameter int ENTRY_W = 16,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = idx_width(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/unpool_2x2.sv
// ============================================================================
// Module      : unpool_2x2
// Description : Streaming 2x2 stride-2 upsampler (nearest-neighbour, or
//               max-unpool when MAX_UNPOOL_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unpool_2x2
    import unpool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IN_WIDTH   = 4,
    parameter int IN_HEIGHT  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic [1:0]                   din_idx,
    input  logic                         valid_in,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         valid_out,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int COL_W = idx_width(IN_WIDTH);
    localparam int ROW_W = idx_width(IN_HEIGHT);
`ifdef MAX_UNPOOL_EN
    localparam int ENTRY_W = DATA_WIDTH + 2;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   icol_q,  icol_d;
    logic [ROW_W-1:0]   orow_q,  orow_d;
    logic               sub_x_q, sub_x_d;
    logic               valid_q, valid_d;
    logic [ENTRY_W-1:0] hold_q,  hold_d;

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_col_end;
    logic [COL_W-1:0]   w_wr_addr;
    logic [ENTRY_W-1:0] w_wr_data;
    logic [ENTRY_W-1:0] w_rd_data;
    logic [ENTRY_W-1:0] w_cur;
    logic [1:0]         w_pos;

    assign w_col_end  = (icol_q == COL_LAST);
    assign w_in_xfer  = valid_in && in_ready;
    assign w_out_xfer = valid_q && out_ready;

`ifdef MAX_UNPOOL_EN
    assign w_wr_data = {din_idx, din};
`else
    logic w_unused_idx;
    assign w_wr_data    = din;
    assign w_unused_idx = ^din_idx;
`endif

    unpool_row_buf #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (IN_WIDTH),
        .ADDR_W  (COL_W)
    ) u_row_buf (
        .clk     (clk),
        .wr_en   (w_in_xfer),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data),
        .rd_addr (icol_q),
        .rd_data (w_rd_data)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_TOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icol_q  <= '0;
            orow_q  <= '0;
            sub_x_q <= 1'b0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            icol_q  <= icol_d;
            orow_q  <= orow_d;
            sub_x_q <= sub_x_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        icol_d  = icol_q;
        orow_d  = orow_q;
        sub_x_d = sub_x_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        case (state_q)
            S_TOP: begin
                if (w_out_xfer) begin
                    if (!sub_x_q) begin
                        sub_x_d = 1'b1;
                    end else if (w_col_end) begin
                        state_d = S_BOT;
                        icol_d  = '0;
                        sub_x_d = 1'b0;
                        valid_d = 1'b1;
                    end else begin
                        icol_d  = icol_q + COL_W'(1);
                        sub_x_d = 1'b0;
                        valid_d = 1'b0;
                    end
                end
                // A new value may arrive in the same cycle the previous
                // right pixel leaves; it then owns the next column.
                if (w_in_xfer) begin
                    hold_d  = w_wr_data;
                    valid_d = 1'b1;
                    sub_x_d = 1'b0;
                end
            end
            S_BOT: begin
                if (w_out_xfer) begin
                    if (!sub_x_q) begin
                        sub_x_d = 1'b1;
                    end else if (w_col_end) begin
                        state_d = S_TOP;
                        icol_d  = '0;
                        sub_x_d = 1'b0;
                        valid_d = 1'b0;
                        orow_d  = (orow_q == ROW_LAST) ? '0 : orow_q + ROW_W'(1);
                    end else begin
                        icol_d  = icol_q + COL_W'(1);
                        sub_x_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_TOP;
            end
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == S_TOP) &&
                    (!valid_q || (out_ready && sub_x_q && !w_col_end));
        w_wr_addr = valid_q ? (icol_q + COL_W'(1)) : icol_q;
        valid_out = valid_q;
        w_cur     = (state_q == S_BOT) ? w_rd_data : hold_q;
        if (state_q == S_BOT) begin
            w_pos = sub_x_q ? POS_BR : POS_BL;
        end else begin
            w_pos = sub_x_q ? POS_TR : POS_TL;
        end
        out_last  = (w_pos == POS_BR) && (orow_q == ROW_LAST) && w_col_end;
`ifdef MAX_UNPOOL_EN
        dout = (w_pos == w_cur[ENTRY_W-1 -: 2]) ? w_cur[DATA_WIDTH-1:0] : '0;
`else
        dout = w_cur;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_unpool_2x2.sv
// ============================================================================
// Module      : tb_unpool_2x2
// Description : Directed self-checking bench for unpool_2x2 (2x2 pooled
//               frames). Expectations follow MAX_UNPOOL_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unpool_2x2;

    localparam int DW   = 16;
    localparam int IW   = 2;
    localparam int IH   = 2;
    localparam int NPIX = 4 * IW * IH;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] din;
    logic [1:0]           din_idx;
    logic                 valid_in;
    logic                 in_ready;
    logic signed [DW-1:0] dout;
    logic                 valid_out;
    logic                 out_ready;
    logic                 out_last;

    int n_cmp = 0;
    int n_bad = 0;
    int f_val [4];
    int f_idx [4];

    always #5 clk = ~clk;

    unpool_2x2 #(
        .DATA_WIDTH (DW),
        .IN_WIDTH   (IW),
        .IN_HEIGHT  (IH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_idx   (din_idx),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .dout      (dout),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output pixel k of a 4x4 frame built from the four pooled values.
    function automatic int exp_pix(input int k);
        int r;
        int c;
        int b;
        int p;
        r = k / 4;
        c = k % 4;
        b = (r / 2) * 2 + (c / 2);
        p = (r % 2) * 2 + (c % 2);
`ifdef MAX_UNPOOL_EN
        return (p == f_idx[b]) ? f_val[b] : 0;
`else
        if (p < 0) return 0;
        return f_val[b];
`endif
    endfunction

    task automatic run_frame(input int gap, input bit toggle, input int stop_at);
        int  in_k    = 0;
        int  out_k   = 0;
        int  gap_cnt = 0;
        int  cyc     = 0;
        bit  bottom;
        bit  in_x;
        bit  out_x;
        while (out_k < stop_at && cyc < 400) begin
            @(negedge clk);
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (in_k < 4 && gap_cnt == 0) begin
                valid_in = 1'b1;
                din      = DW'(f_val[in_k]);
                din_idx  = 2'(f_idx[in_k]);
            end else begin
                valid_in = 1'b0;
            end
            #1;
            bottom = ((out_k / 4) % 2) == 1;
            if (valid_out) begin
                check_val($sformatf("dout[%0d]", out_k), int'(dout), exp_pix(out_k));
                check_val($sformatf("last[%0d]", out_k), int'(out_last), int'(out_k == NPIX - 1));
            end
            if (bottom) begin
                check_val($sformatf("bot_valid[%0d]", out_k), int'(valid_out), 1);
                check_val($sformatf("bot_ready[%0d]", out_k), int'(in_ready), 0);
            end
            in_x  = valid_in && in_ready;
            out_x = valid_out && out_ready;
            if (in_x) begin
                in_k++;
                gap_cnt = gap;
            end else if (!valid_in && gap_cnt > 0) begin
                gap_cnt--;
            end
            if (out_x) out_k++;
            cyc++;
        end
        check_val("frame_count", out_k, stop_at);
        @(negedge clk);
        valid_in  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        din       = '0;
        din_idx   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_valid", int'(valid_out), 0);
        check_val("rst_dout",  int'(dout), 0);
        check_val("rst_last",  int'(out_last), 0);
        check_val("rst_ready", int'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back inputs, no backpressure
        f_val = '{5, -3, 7, 9};
        f_idx = '{0, 0, 0, 0};
        run_frame(0, 1'b0, NPIX);

        // Alternating backpressure
        run_frame(0, 1'b1, NPIX);

        // Idle gaps between inputs
        run_frame(3, 1'b0, NPIX);

        // Reset after the 6th output, then a fresh frame
        run_frame(0, 1'b0, 6);
        reset    = 1'b1;
        valid_in = 1'b0;
        #1;
        check_val("midrst_valid", int'(valid_out), 0);
        check_val("midrst_last",  int'(out_last), 0);
        @(negedge clk);
        check_val("midrst_valid2", int'(valid_out), 0);
        reset = 1'b0;
        f_val = '{1, 2, 3, 4};
        f_idx = '{1, 2, 3, 0};
        run_frame(0, 1'b0, NPIX);

        // Argmax-tagged frame
        f_val = '{8, 4, -2, 6};
        f_idx = '{3, 0, 1, 2};
        run_frame(0, 1'b0, NPIX);

        // Two consecutive frames without reset
        f_val = '{10, -20, 30, -40};
        f_idx = '{2, 3, 0, 1};
        run_frame(0, 1'b0, NPIX);
        f_val = '{-32768, 32767, 0, -1};
        f_idx = '{0, 1, 2, 3};
        run_frame(1, 1'b1, NPIX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/unpool_2x2.md
Name: unpool_2x2

Overview:
Streaming 2x2 upsampler (stride 2) that does the reverse of the 2x2 maxpool stage. It consumes a raster of pooled values of size IN_WIDTH x IN_HEIGHT. It emits a raster of size 2*IN_WIDTH x 2*IN_HEIGHT, one pixel per handshake. It sits on the decoder/reconstruction path after a pool stage or feature buffer and feeds later conv stages. Each output row is replayed from a one-row buffer, so input is stalled with in_ready while the bottom row of each block is produced.

Parameters:
DATA_WIDTH, 16, signed pixel width
IN_WIDTH, 4, pooled row length (output row = 2*IN_WIDTH)
IN_HEIGHT, 4, pooled rows per frame (output rows = 2*IN_HEIGHT)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
din  input  DATA_WIDTH  signed pooled value
din_idx  input  2  argmax position of din (0=TL,1=TR,2=BL,3=BR); ignored unless MAX_UNPOOL_EN
valid_in  input  1  din/din_idx valid
in_ready  output  1  block accepts din this cycle (transfer = valid_in && in_ready)
dout  output  DATA_WIDTH  signed output pixel, raster order
valid_out  output  1  dout valid
out_ready  input  1  downstream accepts dout (transfer = valid_out && out_ready)
out_last  output  1  high with the final pixel of the output frame

Behaviour:
- Decided: one clock clk; reset is asynchronous and active-high.
- Reset values: dout=0, valid_out=0, out_last=0. State=S_TOP; icol, orow, sub_x are all 0. Row buffer contents are don't-care and are not reset.
- Combinational in_ready = (state==S_TOP) && (!valid_out || (out_ready && sub_x==1 && icol!=IN_WIDTH-1)).
- S_TOP (top row of each 2x2 block):
  - On an input transfer: write {din,din_idx} to buf[icol]; load the holding register; next cycle valid_out=1 with sub_x=0 (left pixel). Latency is 1 cycle from input transfer to dout.
  - On an output transfer with sub_x=0: sub_x<=1 and emit the right pixel from the same holding value.
  - On an output transfer with sub_x=1: if icol==IN_WIDTH-1, go to S_BOT with icol=0 and load buf[0]. Otherwise icol++. valid_out drops unless an input transfers in the same cycle.
- S_BOT (bottom row): in_ready=0. Emit buf[icol] as a left then right pair. valid_out stays high back-to-back; each output transfer advances sub_x and then icol.
  - After the right pixel of icol==IN_WIDTH-1: go to S_TOP, icol=0, valid_out=0.
  - orow++; orow wraps to 0 after IN_HEIGHT-1.
- out_last=1 only when state==S_BOT, orow==IN_HEIGHT-1, icol==IN_WIDTH-1, sub_x==1.
- Backpressure: while valid_out && !out_ready, dout, out_last and all counters hold.
- Throughput:
  - Top row: at most one input per 2 cycles, one output per cycle when out_ready=1 and input keeps up.
  - Bottom row: one output per cycle.
- Pixel value: nearest-neighbour replication; every output of a block equals its pooled value. No arithmetic; DATA_WIDTH is preserved.
- Gaps in valid_in are legal: valid_out simply deasserts between blocks in S_TOP.
- Reset asserted mid-frame: outputs clear immediately. The next frame starts at output pixel (0,0); partial frame data is discarded.

Optional Feature:
MAX_UNPOOL_EN:
- Defined: max-unpool mode. Output position p = {bottom_row, sub_x} (S_TOP gives 0/1, S_BOT gives 2/3). dout = value when p==stored din_idx, else 0. din_idx is stored alongside the value in the row buffer.
- Undefined: din_idx is ignored and not stored, so the buffer is DATA_WIDTH wide; replication only.

Decomposition:
- Package unpool_pkg: state enum {S_TOP,S_BOT}; position constants POS_TL=0, POS_TR=1, POS_BL=2, POS_BR=3.
- One sub-module, unpool_row_buf: IN_WIDTH-entry register array with write port (S_TOP) and read port (S_BOT), never used simultaneously. Entry width is DATA_WIDTH, plus 2 bits when MAX_UNPOOL_EN is defined.

Test Plan:
- IN_WIDTH=2, IN_HEIGHT=2, out_ready=1, inputs 5,-3,7,9 (back-to-back valid_in) -> 16 outputs: 5 5 -3 -3 / 5 5 -3 -3 / 7 7 9 9 / 7 7 9 9. out_last only on the 16th. in_ready=0 throughout both bottom rows.
- Same inputs, out_ready toggling 1,0 each cycle -> identical pixel sequence, dout stable during stalls, no input accepted while in S_BOT.
- valid_in with 3 idle cycles between inputs -> valid_out gaps only in the top rows; bottom rows are emitted contiguously.
- Reset asserted after the 6th output of the first frame, then new inputs 1,2,3,4 -> valid_out=0 during reset; next outputs start at 1 1 2 2 with a correct out_last at pixel 16.
- MAX_UNPOOL_EN, inputs (8,idx3),(4,idx0),(-2,idx1),(6,idx2) -> rows: 0 0 4 0 / 0 8 0 0 / 0 -2 0 0 / 0 0 6 0.
- Two consecutive frames without reset -> orow wraps; the second frame's first pixel follows the first frame's out_last with no corruption.
